// File: rtl/uart_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sequencer_pkg
// Purpose  : Shared constants for the UART command sequencer: frame opcodes,
//            FSM state encoding and the register-file slots that hold the
//            ALU operands.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_sequencer_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] c_OP_WR        = 8'hAA;  // wr(addr, data)
    localparam logic [7:0] c_OP_RD        = 8'hBB;  // rd(addr)
    localparam logic [7:0] c_OP_ALU       = 8'hCC;  // alu(A, B, fun)
    localparam logic [7:0] c_OP_ALU_REUSE = 8'hDD;  // alu(fun) on stored operands

    // Register-file slots the ALU reads its operands from
    localparam int c_RF_ADDR_A = 0;
    localparam int c_RF_ADDR_B = 1;

    // FSM state encoding
    localparam int c_STATE_W = 4;
    localparam logic [c_STATE_W-1:0] c_S_IDLE     = 4'd0;
    localparam logic [c_STATE_W-1:0] c_S_GET_ADDR = 4'd1;
    localparam logic [c_STATE_W-1:0] c_S_GET_DATA = 4'd2;
    localparam logic [c_STATE_W-1:0] c_S_RF_WR    = 4'd3;
    localparam logic [c_STATE_W-1:0] c_S_RF_RD    = 4'd4;
    localparam logic [c_STATE_W-1:0] c_S_RD_WAIT  = 4'd5;
    localparam logic [c_STATE_W-1:0] c_S_GET_A    = 4'd6;
    localparam logic [c_STATE_W-1:0] c_S_GET_B    = 4'd7;
    localparam logic [c_STATE_W-1:0] c_S_GET_FUN  = 4'd8;
    localparam logic [c_STATE_W-1:0] c_S_ALU_RUN  = 4'd9;
    localparam logic [c_STATE_W-1:0] c_S_ALU_WAIT = 4'd10;
    localparam logic [c_STATE_W-1:0] c_S_TX_B0    = 4'd11;
    localparam logic [c_STATE_W-1:0] c_S_TX_B1    = 4'd12;

endpackage : uart_cmd_sequencer_pkg
`default_nettype wire

// File: rtl/uart_cmd_sequencer_timeout.sv
`default_nettype none
// ============================================================================
// Module   : seq_timeout_cnt
// Purpose  : Saturating wait counter. Held at zero while i_clear is high,
//            counts while i_enable is high, and flags o_expired once it has
//            reached TIMEOUT.
// Ports    : clk       in  system clock
//            rst       in  synchronous active-high reset
//            i_clear   in  force count to zero
//            i_enable  in  advance count by one
//            o_expired out count has reached TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module seq_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == c_LIMIT);

endmodule : seq_timeout_cnt
`default_nettype wire

// File: rtl/uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sequencer
// Purpose  : Turns framed UART RX bytes into register-file writes/reads and
//            ALU operations, and returns read data / ALU results to UART TX.
//            Frames: AA addr data | BB addr | CC A B fun | DD fun.
// Ports    : CLK, RST                      clock, sync active-high reset
//            RX_P_DATA, RX_D_VLD           received byte + 1-cycle valid
//            RF_RD_DATA, RF_RD_DATA_VLD    register-file read return
//            ALU_OUT, ALU_OUT_VLD          ALU result return
//            TX_BUSY                       transmitter not ready
//            RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN   register-file access
//            ALU_EN, ALU_FUN, CLK_GATE_EN  ALU start, function, clock gate
//            TX_P_DATA, TX_D_VLD           byte to transmit, held until taken
//            CMD_ERR                       1-cycle bad opcode / timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_sequencer
    import uart_cmd_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_DATA_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     TX_BUSY,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic                     RF_WR_EN,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic                     RF_RD_EN,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CMD_ERR
);

    logic [c_STATE_W-1:0]  r_state,       w_state_nx;
    logic                  r_is_wr,       w_is_wr_nx;     // AA vs BB while in GET_ADDR
    logic                  r_two_byte,    w_two_byte_nx;  // ALU result needs a second TX byte
    logic [ADDR_WIDTH-1:0] r_addr,        w_addr_nx;
    logic [DATA_WIDTH-1:0] r_res_hi,      w_res_hi_nx;    // ALU result MSB awaiting TX_B1

    logic [ADDR_WIDTH-1:0] r_rf_addr,     w_rf_addr_nx;
    logic                  r_rf_wr_en,    w_rf_wr_en_nx;
    logic [DATA_WIDTH-1:0] r_rf_wr_data,  w_rf_wr_data_nx;
    logic                  r_rf_rd_en,    w_rf_rd_en_nx;
    logic                  r_alu_en,      w_alu_en_nx;
    logic [FUN_WIDTH-1:0]  r_alu_fun,     w_alu_fun_nx;
    logic                  r_clk_gate_en, w_clk_gate_en_nx;
    logic [DATA_WIDTH-1:0] r_tx_data,     w_tx_data_nx;
    logic                  r_tx_vld,      w_tx_vld_nx;
    logic                  r_cmd_err,     w_cmd_err_nx;

    logic w_in_wait;
    logic w_expired;

    // The counter is held clear outside the two wait states, so it always
    // starts from zero on entry.
    assign w_in_wait = (r_state == c_S_RD_WAIT) || (r_state == c_S_ALU_WAIT);

    seq_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (CLK),
        .rst       (RST),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= c_S_IDLE;
            r_is_wr       <= 1'b0;
            r_two_byte    <= 1'b0;
            r_addr        <= '0;
            r_res_hi      <= '0;
            r_rf_addr     <= '0;
            r_rf_wr_en    <= 1'b0;
            r_rf_wr_data  <= '0;
            r_rf_rd_en    <= 1'b0;
            r_alu_en      <= 1'b0;
            r_alu_fun     <= '0;
            r_clk_gate_en <= 1'b0;
            r_tx_data     <= '0;
            r_tx_vld      <= 1'b0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_is_wr       <= w_is_wr_nx;
            r_two_byte    <= w_two_byte_nx;
            r_addr        <= w_addr_nx;
            r_res_hi      <= w_res_hi_nx;
            r_rf_addr     <= w_rf_addr_nx;
            r_rf_wr_en    <= w_rf_wr_en_nx;
            r_rf_wr_data  <= w_rf_wr_data_nx;
            r_rf_rd_en    <= w_rf_rd_en_nx;
            r_alu_en      <= w_alu_en_nx;
            r_alu_fun     <= w_alu_fun_nx;
            r_clk_gate_en <= w_clk_gate_en_nx;
            r_tx_data     <= w_tx_data_nx;
            r_tx_vld      <= w_tx_vld_nx;
            r_cmd_err     <= w_cmd_err_nx;
        end
    end

    always_comb begin
        // Strobes default low; data/level outputs hold their value.
        w_state_nx       = r_state;
        w_is_wr_nx       = r_is_wr;
        w_two_byte_nx    = r_two_byte;
        w_addr_nx        = r_addr;
        w_res_hi_nx      = r_res_hi;
        w_rf_addr_nx     = r_rf_addr;
        w_rf_wr_en_nx    = 1'b0;
        w_rf_wr_data_nx  = r_rf_wr_data;
        w_rf_rd_en_nx    = 1'b0;
        w_alu_en_nx      = 1'b0;
        w_alu_fun_nx     = r_alu_fun;
        w_clk_gate_en_nx = r_clk_gate_en;
        w_tx_data_nx     = r_tx_data;
        w_tx_vld_nx      = r_tx_vld;
        w_cmd_err_nx     = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        c_OP_WR:        begin w_is_wr_nx = 1'b1; w_state_nx = c_S_GET_ADDR; end
                        c_OP_RD:        begin w_is_wr_nx = 1'b0; w_state_nx = c_S_GET_ADDR; end
                        c_OP_ALU:       w_state_nx = c_S_GET_A;
                        c_OP_ALU_REUSE: w_state_nx = c_S_GET_FUN;
                        default:        w_cmd_err_nx = 1'b1;
                    endcase
                end
            end
            c_S_GET_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nx = RX_P_DATA[ADDR_WIDTH-1:0];
                    if (r_is_wr) begin
                        w_state_nx = c_S_GET_DATA;
                    end else begin
                        // Read strobe is registered, so it is high while in RF_RD.
                        w_rf_addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                        w_rf_rd_en_nx = 1'b1;
                        w_state_nx    = c_S_RF_RD;
                    end
                end
            end
            c_S_GET_DATA: begin
                if (RX_D_VLD) begin
                    w_rf_addr_nx    = r_addr;
                    w_rf_wr_data_nx = RX_P_DATA;
                    w_rf_wr_en_nx   = 1'b1;
                    w_state_nx      = c_S_RF_WR;
                end
            end
            c_S_RF_WR: w_state_nx = c_S_IDLE;
            c_S_RF_RD: w_state_nx = c_S_RD_WAIT;
            c_S_RD_WAIT: begin
                // A valid arriving in the expiry cycle still completes the read.
                if (RF_RD_DATA_VLD) begin
                    w_tx_data_nx  = RF_RD_DATA;
                    w_tx_vld_nx   = 1'b1;
                    w_two_byte_nx = 1'b0;
                    w_state_nx    = c_S_TX_B0;
                end else if (w_expired) begin
                    w_cmd_err_nx = 1'b1;
                    w_state_nx   = c_S_IDLE;
                end
            end
            c_S_GET_A: begin
                if (RX_D_VLD) begin
                    w_rf_addr_nx    = ADDR_WIDTH'(c_RF_ADDR_A);
                    w_rf_wr_data_nx = RX_P_DATA;
                    w_rf_wr_en_nx   = 1'b1;
                    w_state_nx      = c_S_GET_B;
                end
            end
            c_S_GET_B: begin
                if (RX_D_VLD) begin
                    w_rf_addr_nx    = ADDR_WIDTH'(c_RF_ADDR_B);
                    w_rf_wr_data_nx = RX_P_DATA;
                    w_rf_wr_en_nx   = 1'b1;
                    w_state_nx      = c_S_GET_FUN;
                end
            end
            c_S_GET_FUN: begin
                if (RX_D_VLD) begin
                    w_alu_fun_nx     = RX_P_DATA[FUN_WIDTH-1:0];
                    w_clk_gate_en_nx = 1'b1;
                    w_alu_en_nx      = 1'b1;
                    w_state_nx       = c_S_ALU_RUN;
                end
            end
            c_S_ALU_RUN: w_state_nx = c_S_ALU_WAIT;
            c_S_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    w_res_hi_nx      = ALU_OUT[ALU_OUT_WIDTH-1:DATA_WIDTH];
                    w_tx_data_nx     = ALU_OUT[DATA_WIDTH-1:0];
                    w_tx_vld_nx      = 1'b1;
                    w_two_byte_nx    = 1'b1;
                    w_clk_gate_en_nx = 1'b0;
                    w_state_nx       = c_S_TX_B0;
                end else if (w_expired) begin
                    w_cmd_err_nx     = 1'b1;
                    w_clk_gate_en_nx = 1'b0;
                    w_state_nx       = c_S_IDLE;
                end
            end
            c_S_TX_B0: begin
                // TX_D_VLD is already high here; the byte is taken on !TX_BUSY.
                if (!TX_BUSY) begin
                    if (r_two_byte) begin
                        w_tx_data_nx = r_res_hi;
                        w_state_nx   = c_S_TX_B1;
                    end else begin
                        w_tx_vld_nx  = 1'b0;
                        w_state_nx   = c_S_IDLE;
                    end
                end
            end
            c_S_TX_B1: begin
                if (!TX_BUSY) begin
                    w_tx_vld_nx = 1'b0;
                    w_state_nx  = c_S_IDLE;
                end
            end
            default: w_state_nx = c_S_IDLE;
        endcase
    end

    assign RF_ADDR     = r_rf_addr;
    assign RF_WR_EN    = r_rf_wr_en;
    assign RF_WR_DATA  = r_rf_wr_data;
    assign RF_RD_EN    = r_rf_rd_en;
    assign ALU_EN      = r_alu_en;
    assign ALU_FUN     = r_alu_fun;
    assign CLK_GATE_EN = r_clk_gate_en;
    assign TX_P_DATA   = r_tx_data;
    assign TX_D_VLD    = r_tx_vld;
    assign CMD_ERR     = r_cmd_err;

endmodule : uart_cmd_sequencer
`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_sequencer
// Purpose  : Directed self-checking bench for uart_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_sequencer;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_DATA_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_BUSY;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic [7:0]  RF_WR_DATA;
    logic        RF_RD_EN;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CMD_ERR;

    always #5 CLK = ~CLK;

    uart_cmd_sequencer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16), .FUN_WIDTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .CMD_ERR(CMD_ERR)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- event recorder (samples on the falling edge) ----------
    int         cyc = 0;
    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] tx_q[$];
    int         n_rd, n_alu, n_err, n_unstable;
    logic [3:0] rd_addr, alu_fun;
    int         alu_cyc, err_cyc;
    logic       p_vld, p_busy;
    logic [7:0] p_data;

    always @(posedge CLK) cyc = cyc + 1;

    always @(negedge CLK) begin
        if (RF_WR_EN === 1'b1) begin wr_addr_q.push_back(RF_ADDR); wr_data_q.push_back(RF_WR_DATA); end
        if (RF_RD_EN === 1'b1) begin n_rd++; rd_addr = RF_ADDR; end
        if (ALU_EN === 1'b1)   begin n_alu++; alu_fun = ALU_FUN; alu_cyc = cyc; end
        if (CMD_ERR === 1'b1)  begin n_err++; err_cyc = cyc; end
        if (TX_D_VLD === 1'b1 && TX_BUSY === 1'b0) tx_q.push_back(TX_P_DATA);
        if (p_vld === 1'b1 && p_busy === 1'b1 && (TX_D_VLD !== 1'b1 || TX_P_DATA !== p_data))
            n_unstable++;
        p_vld  = TX_D_VLD;
        p_busy = TX_BUSY;
        p_data = TX_P_DATA;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        tick();
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
        n_rd = 0; n_alu = 0; n_err = 0; n_unstable = 0;
        rd_addr = '0; alu_fun = '0; alu_cyc = 0; err_cyc = 0;
    endtask

    task automatic pulse_alu(input logic [15:0] v);
        ALU_OUT     = v;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
    endtask

    task automatic pulse_rf(input logic [7:0] v);
        RF_RD_DATA     = v;
        RF_RD_DATA_VLD = 1'b1;
        tick();
        RF_RD_DATA_VLD = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if ({RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD, CMD_ERR} !== 30'd0)
            begin errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0"); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_write();
        clear_mon();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        repeat (4) tick();
        checks++;
        if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL wr_count: got %0d required 1", wr_addr_q.size()); end
        else begin
            checks++;
            if (wr_addr_q[0] !== 4'h5) begin errors++; $display("FAIL wr_addr: got %0h required 5", wr_addr_q[0]); end
            checks++;
            if (wr_data_q[0] !== 8'h3C) begin errors++; $display("FAIL wr_data: got %0h required 3c", wr_data_q[0]); end
        end
        checks++;
        if (tx_q.size() !== 0 || n_rd !== 0 || n_alu !== 0 || n_err !== 0)
            begin errors++; $display("FAIL wr_side_effects: got tx=%0d rd=%0d alu=%0d err=%0d required all 0",
                                     tx_q.size(), n_rd, n_alu, n_err); end
    endtask

    task automatic test_read();
        clear_mon();
        send_byte(8'hBB); send_byte(8'h05);
        tick();
        pulse_rf(8'h3C);
        repeat (6) tick();
        checks++;
        if (n_rd !== 1 || rd_addr !== 4'h5)
            begin errors++; $display("FAIL rd_strobe: got count=%0d addr=%0h required 1/5", n_rd, rd_addr); end
        checks++;
        if (tx_q.size() !== 1) begin errors++; $display("FAIL rd_tx_count: got %0d required 1", tx_q.size()); end
        else begin
            checks++;
            if (tx_q[0] !== 8'h3C) begin errors++; $display("FAIL rd_tx_data: got %0h required 3c", tx_q[0]); end
        end
        checks++;
        if (TX_D_VLD !== 1'b0) begin errors++; $display("FAIL rd_tx_release: got %0b required 0", TX_D_VLD); end
    endtask

    task automatic test_alu_full();
        clear_mon();
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        checks++;
        if (n_alu !== 1 || alu_fun !== 4'h0 || CLK_GATE_EN !== 1'b1)
            begin errors++; $display("FAIL alu_start: got en=%0d fun=%0h gate=%0b required 1/0/1",
                                     n_alu, alu_fun, CLK_GATE_EN); end
        tick();
        pulse_alu(16'h0046);
        checks++;
        if (CLK_GATE_EN !== 1'b0) begin errors++; $display("FAIL alu_gate_drop: got %0b required 0", CLK_GATE_EN); end
        repeat (6) tick();
        checks++;
        if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL alu_wr_count: got %0d required 2", wr_addr_q.size()); end
        else begin
            checks++;
            if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !== {4'h0, 8'h12, 4'h1, 8'h34})
                begin errors++; $display("FAIL alu_operands: got %0h=%0h %0h=%0h required 0=12 1=34",
                                         wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]); end
        end
        checks++;
        if (tx_q.size() !== 2) begin errors++; $display("FAIL alu_tx_count: got %0d required 2", tx_q.size()); end
        else begin
            checks++;
            if ({tx_q[0], tx_q[1]} !== 16'h4600)
                begin errors++; $display("FAIL alu_tx_bytes: got %0h %0h required 46 00", tx_q[0], tx_q[1]); end
        end
    endtask

    task automatic test_tx_busy();
        clear_mon();
        TX_BUSY = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        checks++;
        if (n_alu !== 1 || alu_fun !== 4'h2)
            begin errors++; $display("FAIL busy_alu_start: got en=%0d fun=%0h required 1/2", n_alu, alu_fun); end
        checks++;
        if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL busy_no_wr: got %0d required 0", wr_addr_q.size()); end
        tick();
        pulse_alu(16'h1234);
        repeat (5) tick();
        checks++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h34)
            begin errors++; $display("FAIL busy_hold: got vld=%0b data=%0h required 1/34", TX_D_VLD, TX_P_DATA); end
        TX_BUSY = 1'b0;
        repeat (6) tick();
        checks++;
        if (n_unstable !== 0) begin errors++; $display("FAIL busy_stable: got %0d changes required 0", n_unstable); end
        checks++;
        if (tx_q.size() !== 2) begin errors++; $display("FAIL busy_tx_count: got %0d required 2", tx_q.size()); end
        else begin
            checks++;
            if ({tx_q[0], tx_q[1]} !== 16'h3412)
                begin errors++; $display("FAIL busy_tx_bytes: got %0h %0h required 34 12", tx_q[0], tx_q[1]); end
        end
    endtask

    task automatic test_bad_opcode();
        clear_mon();
        send_byte(8'h77);
        repeat (3) tick();
        checks++;
        if (n_err !== 1) begin errors++; $display("FAIL bad_op_err: got %0d pulses required 1", n_err); end
        checks++;
        if (wr_addr_q.size() !== 0 || n_rd !== 0 || n_alu !== 0 || tx_q.size() !== 0)
            begin errors++; $display("FAIL bad_op_strobes: got wr=%0d rd=%0d alu=%0d tx=%0d required all 0",
                                     wr_addr_q.size(), n_rd, n_alu, tx_q.size()); end
        // The sequencer must still be in IDLE and accept a fresh frame.
        clear_mon();
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h99);
        repeat (3) tick();
        checks++;
        if (wr_addr_q.size() !== 1 || wr_data_q[0] !== 8'h99)
            begin errors++; $display("FAIL bad_op_recover: got %0d writes required 1 of 99", wr_addr_q.size()); end
    endtask

    task automatic test_timeout();
        bit seen;
        clear_mon();
        send_byte(8'hDD); send_byte(8'h01);
        seen = 1'b0;
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            if (n_err > 0) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL timeout_err: got no CMD_ERR required one"); end
        else begin
            // Strobe-to-error spacing: TIMEOUT wait cycles plus the ALU_RUN
            // cycle and register stages.
            checks++;
            if ((err_cyc - alu_cyc) < TIMEOUT || (err_cyc - alu_cyc) > TIMEOUT + 3)
                begin errors++; $display("FAIL timeout_delay: got %0d cycles required %0d..%0d",
                                         err_cyc - alu_cyc, TIMEOUT, TIMEOUT + 3); end
        end
        tick();
        checks++;
        if (CLK_GATE_EN !== 1'b0 || n_err !== 1 || tx_q.size() !== 0)
            begin errors++; $display("FAIL timeout_cleanup: got gate=%0b err=%0d tx=%0d required 0/1/0",
                                     CLK_GATE_EN, n_err, tx_q.size()); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_byte(8'hDD); send_byte(8'h03);
        repeat (3) tick();
        checks++;
        if (CLK_GATE_EN !== 1'b1) begin errors++; $display("FAIL midrst_pre_gate: got %0b required 1", CLK_GATE_EN); end
        RST = 1'b1;
        tick();
        checks++;
        if ({RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD, CMD_ERR} !== 30'd0)
            begin errors++; $display("FAIL midrst_outputs: got nonzero outputs, required all 0"); end
        RST = 1'b0;
        clear_mon();
        tick();
        pulse_alu(16'hBEEF);
        repeat (8) tick();
        checks++;
        if (tx_q.size() !== 0 || n_err !== 0 || CLK_GATE_EN !== 1'b0)
            begin errors++; $display("FAIL midrst_late_valid: got tx=%0d err=%0d gate=%0b required 0/0/0",
                                     tx_q.size(), n_err, CLK_GATE_EN); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_byte(8'hAA); send_byte(8'h9A); send_byte(8'h11);   // addr upper nibble ignored
        send_byte(8'hBB); send_byte(8'hF7);
        pulse_rf(8'hA5);
        repeat (4) tick();
        send_byte(8'hDD); send_byte(8'hF3);                    // fun upper nibble ignored
        checks++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 4'hA || wr_data_q[0] !== 8'h11)
            begin errors++; $display("FAIL b2b_wr: got %0d writes addr=%0h required 1 at a=11",
                                     wr_addr_q.size(), wr_addr_q[0]); end
        checks++;
        if (n_rd !== 1 || rd_addr !== 4'h7) begin errors++; $display("FAIL b2b_rd_addr: got %0h required 7", rd_addr); end
        checks++;
        if (alu_fun !== 4'h3) begin errors++; $display("FAIL b2b_fun_mask: got %0h required 3", alu_fun); end
        tick();
        pulse_alu(16'h00FF);
        repeat (6) tick();
        checks++;
        if (tx_q.size() !== 3) begin errors++; $display("FAIL b2b_tx_count: got %0d required 3", tx_q.size()); end
        else begin
            checks++;
            if ({tx_q[0], tx_q[1], tx_q[2]} !== 24'hA5FF00)
                begin errors++; $display("FAIL b2b_tx_bytes: got %0h %0h %0h required a5 ff 00",
                                         tx_q[0], tx_q[1], tx_q[2]); end
        end
    endtask

    initial begin
        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RD_DATA = '0; RF_RD_DATA_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0; TX_BUSY = 1'b0;
        clear_mon();
        test_reset();
        test_write();
        test_read();
        test_alu_full();
        test_tx_busy();
        test_bad_opcode();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_cmd_sequencer
`default_nettype wire
